// File: rtl/issue_ctrl.sv
// Issue-stage controller: single-entry issue register between the instruction
// queue and the ROB / RS / LSB dispatch ports, with stall and flush handling.
module issue_ctrl #(
    parameter int                  ROB_IDX_W  = 4,
    parameter int                  OPENUM_W   = 6,
    parameter logic [OPENUM_W-1:0] NOP_OPENUM = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 flush,

    input  logic                 iq_valid,
    input  logic [31:0]          iq_inst,
    input  logic [31:0]          iq_pc,
    output logic                 iq_pop,

    output logic [31:0]          dec_inst,
    input  logic [OPENUM_W-1:0]  dec_openum,
    input  logic [4:0]           dec_rd,
    input  logic [4:0]           dec_rs1,
    input  logic [4:0]           dec_rs2,
    input  logic [31:0]          dec_imm,
    input  logic                 dec_is_jump,
    input  logic                 dec_is_store,

    input  logic                 rob_full,
    input  logic                 rs_full,
    input  logic                 lsb_full,
    input  logic [ROB_IDX_W-1:0] rob_tail,

    output logic                 to_rob_valid,
    output logic                 to_rs_valid,
    output logic                 to_lsb_valid,
    output logic [OPENUM_W-1:0]  iss_openum,
    output logic [4:0]           iss_rd,
    output logic [4:0]           iss_rs1,
    output logic [4:0]           iss_rs2,
    output logic [31:0]          iss_imm,
    output logic [31:0]          iss_pc,
    output logic [ROB_IDX_W-1:0] iss_tag,
    output logic                 iss_is_jump,
    output logic                 iss_is_store
);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic {
        ST_EMPTY,
        ST_HELD
    } state_t;

    typedef enum logic [1:0] {
        TGT_RS,
        TGT_LSB,
        TGT_DROP
    } tgt_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_inst;
    logic [31:0]         r_pc;
    logic                r_rob_v;
    logic                r_rs_v;
    logic                r_lsb_v;

    logic [OPENUM_W-1:0]  r_openum;
    logic [4:0]           r_rd;
    logic [4:0]           r_rs1;
    logic [4:0]           r_rs2;
    logic [31:0]          r_imm;
    logic [31:0]          r_iss_pc;
    logic [ROB_IDX_W-1:0] r_tag;
    logic                 r_is_jump;
    logic                 r_is_store;

    logic [6:0]          w_opcode;
    logic                w_is_nop;
    logic                w_is_mem;
    logic                w_held;
    logic                w_room;
    logic                w_fire;
    logic                w_issue;
    logic                w_pop;
    logic                w_load;
    tgt_t                w_tgt;

    assign w_held   = (r_state == ST_HELD);
    assign w_opcode = r_inst[6:0];
    assign w_is_nop = (dec_openum == NOP_OPENUM);
    assign w_is_mem = (w_opcode == OPC_LOAD) || (w_opcode == OPC_STORE);

    // An unknown opcode is dropped even if it happens to look like memory.
    always_comb begin
        w_tgt = TGT_RS;
        priority case (1'b1)
            w_is_nop: w_tgt = TGT_DROP;
            w_is_mem: w_tgt = TGT_LSB;
            default:  w_tgt = TGT_RS;
        endcase
    end

    always_comb begin
        w_room = 1'b0;
        if (!rob_full) begin
            if (w_tgt == TGT_LSB) w_room = !lsb_full;
            else                  w_room = !rs_full;
        end
    end

    assign w_fire  = w_held && rdy && !flush
                   && ((w_tgt == TGT_DROP) || w_room);
    assign w_issue = w_fire && (w_tgt != TGT_DROP);
    assign w_pop   = rdy && !flush && iq_valid && (!w_held || w_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        if (rdy) begin
            if (flush) begin
                w_state_nxt = ST_EMPTY;
            end else if (w_pop) begin
                w_state_nxt = ST_HELD;
                w_load      = 1'b1;
            end else if (w_fire) begin
                w_state_nxt = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst <= '0;
            r_pc   <= '0;
        end else if (w_load) begin
            r_inst <= iq_inst;
            r_pc   <= iq_pc;
        end
    end

    // Pulses only move on rdy edges so a frozen pipe keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rob_v <= 1'b0;
            r_rs_v  <= 1'b0;
            r_lsb_v <= 1'b0;
        end else if (rdy) begin
            r_rob_v <= w_issue;
            r_rs_v  <= w_issue && (w_tgt == TGT_RS);
            r_lsb_v <= w_issue && (w_tgt == TGT_LSB);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_openum   <= '0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_imm      <= '0;
            r_iss_pc   <= '0;
            r_tag      <= '0;
            r_is_jump  <= 1'b0;
            r_is_store <= 1'b0;
        end else if (w_issue) begin
            r_openum   <= dec_openum;
            r_rd       <= dec_rd;
            r_rs1      <= dec_rs1;
            r_rs2      <= dec_rs2;
            r_imm      <= dec_imm;
            r_iss_pc   <= r_pc;
            r_tag      <= rob_tail;
            r_is_jump  <= dec_is_jump;
            r_is_store <= dec_is_store;
        end
    end

    assign iq_pop       = w_pop;
    assign dec_inst     = w_held ? r_inst : 32'h0;
    assign to_rob_valid = r_rob_v;
    assign to_rs_valid  = r_rs_v;
    assign to_lsb_valid = r_lsb_v;
    assign iss_openum   = r_openum;
    assign iss_rd       = r_rd;
    assign iss_rs1      = r_rs1;
    assign iss_rs2      = r_rs2;
    assign iss_imm      = r_imm;
    assign iss_pc       = r_iss_pc;
    assign iss_tag      = r_tag;
    assign iss_is_jump  = r_is_jump;
    assign iss_is_store = r_is_store;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: table of per-cycle vectors plus
// hand sequences for reset behaviour.
module tb_issue_ctrl;

    localparam logic [31:0] I_A   = 32'h00500093;
    localparam logic [31:0] I_B   = 32'h00A00113;
    localparam logic [31:0] I_C   = 32'h00F00193;
    localparam logic [31:0] I_LW  = 32'h0080A103;
    localparam logic [31:0] I_SW  = 32'h0020A423;
    localparam logic [31:0] I_INV = 32'hFFFFFFFF;
    localparam logic [31:0] I_BEQ = 32'h00208463;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        flush;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_pop;
    logic [31:0] dec_inst;
    logic [5:0]  dec_openum;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [31:0] dec_imm;
    logic        dec_is_jump;
    logic        dec_is_store;
    logic        rob_full;
    logic        rs_full;
    logic        lsb_full;
    logic [3:0]  rob_tail;
    logic        to_rob_valid;
    logic        to_rs_valid;
    logic        to_lsb_valid;
    logic [5:0]  iss_openum;
    logic [4:0]  iss_rd;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic [31:0] iss_imm;
    logic [31:0] iss_pc;
    logic [3:0]  iss_tag;
    logic        iss_is_jump;
    logic        iss_is_store;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc),
        .iq_pop(iq_pop), .dec_inst(dec_inst),
        .dec_openum(dec_openum), .dec_rd(dec_rd),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_imm(dec_imm),
        .dec_is_jump(dec_is_jump), .dec_is_store(dec_is_store),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .rob_tail(rob_tail),
        .to_rob_valid(to_rob_valid), .to_rs_valid(to_rs_valid),
        .to_lsb_valid(to_lsb_valid), .iss_openum(iss_openum),
        .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_tag(iss_tag),
        .iss_is_jump(iss_is_jump), .iss_is_store(iss_is_store)
    );

    // Minimal decoder model; opcode 0 enum means NOP.
    always_comb begin
        logic [6:0] op;
        op           = dec_inst[6:0];
        dec_openum   = 6'd0;
        dec_rd       = dec_inst[11:7];
        dec_rs1      = dec_inst[19:15];
        dec_rs2      = dec_inst[24:20];
        dec_imm      = {{20{dec_inst[31]}}, dec_inst[31:20]};
        dec_is_jump  = 1'b0;
        dec_is_store = 1'b0;
        case (op)
            7'b0010011: dec_openum = 6'd1;
            7'b0000011: dec_openum = 6'd2;
            7'b0100011: begin
                dec_openum   = 6'd3;
                dec_is_store = 1'b1;
                dec_rd       = 5'd0;
                dec_imm      = {{20{dec_inst[31]}},
                                dec_inst[31:25], dec_inst[11:7]};
            end
            7'b1100011: begin
                dec_openum  = 6'd4;
                dec_is_jump = 1'b1;
                dec_rd      = 5'd0;
            end
            default: dec_openum = 6'd0;
        endcase
    end

    typedef struct packed {
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        rf;
        logic        sf;
        logic        lf;
        logic        fl;
        logic        rdy;
        logic [3:0]  tag;
    } in_t;

    typedef struct packed {
        logic        pop;
        logic        rob;
        logic        rs;
        logic        lsb;
        logic        st;
        logic [31:0] pc;
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] dinst;
    } ex_t;

    typedef struct packed {
        in_t i;
        ex_t e;
    } vec_t;

    vec_t tbl[$];

    function automatic in_t vi(logic v, logic [31:0] inst,
        logic [31:0] pc, logic rf, logic sf, logic lf, logic fl,
        logic r, logic [3:0] tag);
        in_t x;
        x = '{v, inst, pc, rf, sf, lf, fl, r, tag};
        return x;
    endfunction

    function automatic ex_t ve(logic pop, logic rob, logic rs,
        logic lsb, logic st, logic [31:0] pc, logic [3:0] tag,
        logic [4:0] rd, logic [31:0] imm, logic [31:0] dinst);
        ex_t x;
        x = '{pop, rob, rs, lsb, st, pc, tag, rd, imm, dinst};
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input in_t t);
        iq_valid = t.v;
        iq_inst  = t.inst;
        iq_pc    = t.pc;
        rob_full = t.rf;
        rs_full  = t.sf;
        lsb_full = t.lf;
        flush    = t.fl;
        rdy      = t.rdy;
        rob_tail = t.tag;
    endtask

    task automatic apply(input vec_t t, input string tg);
        @(negedge clk);
        drive(t.i);
        #1;
        chk({tg, " iq_pop"}, 32'(iq_pop), 32'(t.e.pop));
        @(posedge clk);
        #1;
        chk({tg, " rob_v"}, 32'(to_rob_valid), 32'(t.e.rob));
        chk({tg, " rs_v"}, 32'(to_rs_valid), 32'(t.e.rs));
        chk({tg, " lsb_v"}, 32'(to_lsb_valid), 32'(t.e.lsb));
        chk({tg, " dec_inst"}, dec_inst, t.e.dinst);
        if (t.e.rob) begin
            chk({tg, " iss_pc"}, iss_pc, t.e.pc);
            chk({tg, " iss_tag"}, 32'(iss_tag), 32'(t.e.tag));
            chk({tg, " iss_rd"}, 32'(iss_rd), 32'(t.e.rd));
            chk({tg, " iss_imm"}, iss_imm, t.e.imm);
            chk({tg, " iss_st"}, 32'(iss_is_store), 32'(t.e.st));
        end
    endtask

    initial begin
        drive(vi(0, 0, 0, 0, 0, 0, 0, 1, 0));
        rst_n = 1'b0;

        // single addi
        tbl.push_back('{vi(1, I_A, 32'h0, 0, 0, 0, 0, 1, 3), ve(1, 0, 0, 0, 0, 0, 0, 0, 0, I_A)});
        tbl.push_back('{vi(0, 0, 0, 0, 0, 0, 0, 1, 3), ve(0, 1, 1, 0, 0, 32'h0, 3, 1, 5, 0)});
        tbl.push_back('{vi(0, 0, 0, 0, 0, 0, 0, 1, 3), ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        // back-to-back stream
        tbl.push_back('{vi(1, I_A, 32'h0, 0, 0, 0, 0, 1, 4), ve(1, 0, 0, 0, 0, 0, 0, 0, 0, I_A)});
        tbl.push_back('{vi(1, I_B, 32'h4, 0, 0, 0, 0, 1, 4), ve(1, 1, 1, 0, 0, 32'h0, 4, 1, 5, I_B)});
        tbl.push_back('{vi(1, I_C, 32'h8, 0, 0, 0, 0, 1, 5), ve(1, 1, 1, 0, 0, 32'h4, 5, 2, 10, I_C)});
        tbl.push_back('{vi(0, 0, 0, 0, 0, 0, 0, 1, 6), ve(0, 1, 1, 0, 0, 32'h8, 6, 3, 15, 0)});
        // lw under lsb_full for three cycles
        tbl.push_back('{vi(1, I_LW, 32'h10, 0, 0, 1, 0, 1, 7), ve(1, 0, 0, 0, 0, 0, 0, 0, 0, I_LW)});
        tbl.push_back('{vi(1, I_A, 32'h14, 0, 0, 1, 0, 1, 7), ve(0, 0, 0, 0, 0, 0, 0, 0, 0, I_LW)});
        tbl.push_back('{vi(1, I_A, 32'h14, 0, 0, 1, 0, 1, 7), ve(0, 0, 0, 0, 0, 0, 0, 0, 0, I_LW)});
        tbl.push_back('{vi(1, I_A, 32'h14, 0, 0, 1, 0, 1, 7), ve(0, 0, 0, 0, 0, 0, 0, 0, 0, I_LW)});
        tbl.push_back('{vi(1, I_A, 32'h14, 0, 0, 0, 0, 1, 7), ve(1, 1, 0, 1, 0, 32'h10, 7, 2, 8, I_A)});
        tbl.push_back('{vi(0, 0, 0, 0, 1, 0, 0, 1, 8), ve(0, 0, 0, 0, 0, 0, 0, 0, 0, I_A)});
        tbl.push_back('{vi(0, 0, 0, 0, 0, 0, 0, 1, 8), ve(0, 1, 1, 0, 0, 32'h14, 8, 1, 5, 0)});
        // sw under rob_full
        tbl.push_back('{vi(1, I_SW, 32'h20, 1, 0, 0, 0, 1, 9), ve(1, 0, 0, 0, 0, 0, 0, 0, 0, I_SW)});
        tbl.push_back('{vi(0, 0, 0, 1, 0, 0, 0, 1, 9), ve(0, 0, 0, 0, 0, 0, 0, 0, 0, I_SW)});
        tbl.push_back('{vi(0, 0, 0, 1, 0, 0, 0, 1, 9), ve(0, 0, 0, 0, 0, 0, 0, 0, 0, I_SW)});
        tbl.push_back('{vi(0, 0, 0, 0, 0, 0, 0, 1, 9), ve(0, 1, 0, 1, 1, 32'h20, 9, 0, 8, 0)});
        // invalid then addi, same tag
        tbl.push_back('{vi(1, I_INV, 32'h30, 0, 0, 0, 0, 1, 10), ve(1, 0, 0, 0, 0, 0, 0, 0, 0, I_INV)});
        tbl.push_back('{vi(1, I_A, 32'h34, 0, 0, 0, 0, 1, 10), ve(1, 0, 0, 0, 0, 0, 0, 0, 0, I_A)});
        tbl.push_back('{vi(0, 0, 0, 0, 0, 0, 0, 1, 10), ve(0, 1, 1, 0, 0, 32'h34, 10, 1, 5, 0)});
        // beq stalled on rs_full, then flush as rs frees
        tbl.push_back('{vi(1, I_BEQ, 32'h40, 0, 1, 0, 0, 1, 11), ve(1, 0, 0, 0, 0, 0, 0, 0, 0, I_BEQ)});
        tbl.push_back('{vi(1, I_A, 32'h44, 0, 1, 0, 0, 1, 11), ve(0, 0, 0, 0, 0, 0, 0, 0, 0, I_BEQ)});
        tbl.push_back('{vi(1, I_A, 32'h44, 0, 0, 0, 1, 1, 11), ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        tbl.push_back('{vi(0, 0, 0, 0, 0, 0, 0, 1, 11), ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        // rdy low for two cycles mid-stream
        tbl.push_back('{vi(1, I_A, 32'h50, 0, 0, 0, 0, 1, 11), ve(1, 0, 0, 0, 0, 0, 0, 0, 0, I_A)});
        tbl.push_back('{vi(1, I_B, 32'h54, 0, 0, 0, 0, 1, 11), ve(1, 1, 1, 0, 0, 32'h50, 11, 1, 5, I_B)});
        tbl.push_back('{vi(1, I_C, 32'h58, 0, 0, 0, 0, 0, 12), ve(0, 1, 1, 0, 0, 32'h50, 11, 1, 5, I_B)});
        tbl.push_back('{vi(1, I_C, 32'h58, 0, 0, 0, 0, 0, 12), ve(0, 1, 1, 0, 0, 32'h50, 11, 1, 5, I_B)});
        tbl.push_back('{vi(1, I_C, 32'h58, 0, 0, 0, 0, 1, 12), ve(1, 1, 1, 0, 0, 32'h54, 12, 2, 10, I_C)});
        tbl.push_back('{vi(0, 0, 0, 0, 0, 0, 0, 1, 13), ve(0, 1, 1, 0, 0, 32'h58, 13, 3, 15, 0)});
        tbl.push_back('{vi(0, 0, 0, 0, 0, 0, 0, 1, 13), ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});

        repeat (2) @(posedge clk);
        #1;
        chk("rst iq_pop", 32'(iq_pop), 32'h0);
        chk("rst dec_inst", dec_inst, 32'h0);
        chk("rst rob_v", 32'(to_rob_valid), 32'h0);
        chk("rst rs_v", 32'(to_rs_valid), 32'h0);
        chk("rst lsb_v", 32'(to_lsb_valid), 32'h0);
        chk("rst iss_pc", iss_pc, 32'h0);
        chk("rst iss_imm", iss_imm, 32'h0);
        chk("rst iss_tag", 32'(iss_tag), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++)
            apply(tbl[k], $sformatf("s%0d", k));

        // asynchronous reset while a load is stalled
        apply('{vi(1, I_LW, 32'h60, 0, 0, 1, 0, 1, 14), ve(1, 0, 0, 0, 0, 0, 0, 0, 0, I_LW)}, "ar0");
        @(negedge clk);
        iq_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar dec_inst", dec_inst, 32'h0);
        chk("ar iss_pc", iss_pc, 32'h0);
        chk("ar iss_tag", 32'(iss_tag), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply('{vi(0, 0, 0, 0, 0, 0, 0, 1, 14), ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)}, "ar1");
        apply('{vi(0, 0, 0, 0, 0, 0, 0, 1, 14), ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)}, "ar2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Issue-stage controller that sequences the instruction decoder. It pops one instruction per cycle from the instruction queue and holds it in a single-entry issue register that drives the decoder. Once the target resources have room, it dispatches the decoded fields to the ROB and to exactly one of the reservation station (RS) or the load/store buffer (LSB). It sits between the instruction queue and the ROB/RS/LSB and provides stall and flush handling for the issue stage.

## Interface
- ROB_IDX_W, 4, ROB tag width
- OPENUM_W, 6, width of decoded operation enum
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; low freezes all state
- flush  in  1  mispredict flush, synchronous, highest priority after reset
- iq_valid  in  1  instruction queue has an entry
- iq_inst  in  32  head instruction
- iq_pc  in  32  head PC
- iq_pop  out  1  combinational; pops IQ head on this edge
- dec_inst  out  32  latched instruction to decoder (combinational from issue register)
- dec_openum  in  OPENUM_W  decoder operation
- dec_rd, dec_rs1, dec_rs2  in  5 each  decoder register indices
- dec_imm  in  32  decoder immediate
- dec_is_jump, dec_is_store  in  1 each  decoder flags
- rob_full, rs_full, lsb_full  in  1 each  resource full flags
- rob_tail  in  ROB_IDX_W  tag the ROB will allocate next
- to_rob_valid, to_rs_valid, to_lsb_valid  out  1 each  registered one-cycle issue pulses
- iss_openum  out  OPENUM_W  registered
- iss_rd, iss_rs1, iss_rs2  out  5 each  registered
- iss_imm, iss_pc  out  32 each  registered
- iss_tag  out  ROB_IDX_W  registered ROB tag
- iss_is_jump, iss_is_store  out  1 each  registered

Reset is asynchronous and active-low (rst_n). There is one clock (clk).

## Operation
- Issue register state machine: EMPTY, HELD.
- Target class is derived from the latched opcode (inst[6:0]):
  - 0000011 (load) and 0100011 (store) → LSB.
  - dec_openum == NOP (unknown opcode) → DROP.
  - All others → RS.
- fire = HELD & rdy & !flush & (DROP | (!rob_full & (LSB ? !lsb_full : !rs_full))).
- DROP fires without issuing. It pulses no valid and consumes no tag.
- iq_pop = rdy & !flush & iq_valid & (EMPTY | fire).
- Transitions on a rdy edge:
  - EMPTY + iq_pop → HELD, latching inst and pc.
  - HELD + fire + iq_pop → HELD with the new instruction (back-to-back).
  - HELD + fire + !iq_pop → EMPTY.
  - HELD + !fire → HELD, register unchanged (stall).
- On fire for a non-DROP instruction:
  - to_rob_valid = 1.
  - Exactly one of to_rs_valid / to_lsb_valid = 1.
  - iss_* load the decoder outputs, latched pc, and iss_tag = rob_tail.
- Valid pulses clear on the next rdy edge unless another fire occurs. iss_* data hold their last value.
- flush (with rdy): state → EMPTY, all valids → 0, iq_pop = 0. The held instruction is discarded.
- rdy low: no state change, iq_pop = 0. Valid outputs hold their registered values; consumers qualify them with rdy.
- dec_inst = latched inst when HELD. It is 32'h0 when EMPTY, which decodes to NOP.

## Timing
- Reset: state EMPTY, latched inst/pc = 0, all valids 0, all iss_* 0.
- Latency:
  - IQ head present at edge N (popped) → HELD after N.
  - Earliest fire at edge N+1 → valid high during cycle after N+1.
  - Minimum pop-to-issue latency is 2 edges.
- Throughput is 1 instruction/cycle when resources are free and the IQ is non-empty.
- Full flags are sampled in the fire cycle. A full flag that deasserts allows fire on that same edge.
- Simultaneous cases:
  - flush with fire: flush wins, nothing issued.
  - flush with iq_valid: no pop.
- Reset mid-stall discards the held instruction immediately, asynchronously.
- Tag is sampled from rob_tail on the fire edge. issue_ctrl never computes or wraps tags itself; the ROB owns wrap-around.

## Test plan
- Reset then iq_valid=1, inst=0x00500093 (addi x1,x0,5), pc=0x0: pop at edge 1, then in the cycle after edge 2 to_rob_valid=to_rs_valid=1, iss_rd=1, iss_imm=5, iss_tag=rob_tail.
- Stream three addi back-to-back with no full flags: iq_pop high 3 consecutive cycles, three consecutive RS+ROB pulses with iss_pc 0x0, 0x4, 0x8.
- lw x2,8(x1) (0x0080A103) with lsb_full=1 for 3 cycles: no pulses and iq_pop=0 during the stall; then to_lsb_valid=1, to_rs_valid=0, iss_imm=8.
- sw (0x0020A423) with rob_full=1, rs_full=0: stalls until rob_full drops; then to_lsb_valid=1, iss_is_store=1, iss_rd=0.
- Invalid inst 0xFFFFFFFF followed by addi: the invalid instruction is consumed with no valid pulse, and the addi issues next with the unchanged rob_tail.
- HELD beq under rs_full=1, assert flush: no issue, state EMPTY, iq_pop=0 in the flush cycle. Separately, rdy=0 for 2 cycles mid-stream: no pop or state change, and issue resumes identically afterwards.
